// File: rtl/tx_pause_inject.sv
// rtl/tx_pause_inject.sv - inserts 802.3x PAUSE frames between user frames on the TX byte stream
module tx_pause_inject #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 tx_clk,
    input  logic                 tx_reset,
    input  logic                 pause_req,
    input  logic [15:0]          pause_time_req,
    input  logic [47:0]          mac_addr,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ack,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ack,
    output logic                 pause_busy,
    output logic [CNT_WIDTH-1:0] pause_sent_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_USER  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'd59;

    state_t               state_q, state_d;
    logic                 pend_q, pend_d;
    logic [15:0]          pend_time_q, pend_time_d;
    logic [15:0]          frame_time_q, frame_time_d;
    logic [5:0]           idx_q, idx_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]           pause_byte;

    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            state_q      <= S_IDLE;
            pend_q       <= 1'b0;
            pend_time_q  <= '0;
            frame_time_q <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_time_q  <= pend_time_d;
            frame_time_q <= frame_time_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
        end
    end

    // Frame content is a pure function of idx, so out_data holds while stalled.
    always_comb begin
        pause_byte = 8'h00;
        case (idx_q)
            6'd0:  pause_byte = 8'h01;
            6'd1:  pause_byte = 8'h80;
            6'd2:  pause_byte = 8'hC2;
            6'd3:  pause_byte = 8'h00;
            6'd4:  pause_byte = 8'h00;
            6'd5:  pause_byte = 8'h01;
            6'd6:  pause_byte = mac_addr[47:40];
            6'd7:  pause_byte = mac_addr[39:32];
            6'd8:  pause_byte = mac_addr[31:24];
            6'd9:  pause_byte = mac_addr[23:16];
            6'd10: pause_byte = mac_addr[15:8];
            6'd11: pause_byte = mac_addr[7:0];
            6'd12: pause_byte = 8'h88;
            6'd13: pause_byte = 8'h08;
            6'd14: pause_byte = 8'h00;
            6'd15: pause_byte = 8'h01;
            6'd16: pause_byte = frame_time_q[15:8];
            6'd17: pause_byte = frame_time_q[7:0];
            default: pause_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_time_d  = pend_time_q;
        frame_time_d = frame_time_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        out_data     = 8'h00;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        in_ack       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d      = S_PAUSE;
                    frame_time_d = pend_time_q;
                    pend_d       = 1'b0;
                    idx_d        = '0;
                end else if (in_valid) begin
                    state_d = S_USER;
                end
            end
            S_USER: begin
                out_data  = in_data;
                out_valid = in_valid;
                out_last  = in_last;
                in_ack    = out_ack;
                if (in_valid && out_ack && in_last) begin
                    state_d = S_IDLE;
                end
            end
            S_PAUSE: begin
                out_valid = 1'b1;
                out_data  = pause_byte;
                out_last  = (idx_q == LAST_IDX);
                if (out_ack) begin
                    if (idx_q == LAST_IDX) begin
                        cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request landing as IDLE consumes pend re-arms it for a second frame.
        if (pause_req) begin
            pend_d      = 1'b1;
            pend_time_d = pause_time_req;
        end
    end

    assign pause_busy     = pend_q | (state_q == S_PAUSE);
    assign pause_sent_cnt = cnt_q;

endmodule

// File: tb/tb_tx_pause_inject.sv
// tb/tb_tx_pause_inject.sv - scoreboard bench for tx_pause_inject
module tb_tx_pause_inject;

    logic        tx_clk = 1'b0;
    logic        tx_reset;
    logic        pause_req;
    logic [15:0] pause_time_req;
    logic [47:0] mac_addr;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ack;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ack;
    logic        pause_busy;
    logic [15:0] pause_sent_cnt;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   user_sent = 0;
    bit   rand_ack = 0;
    bit   mon_en = 1;

    tx_pause_inject #(.CNT_WIDTH(16)) dut (
        .tx_clk(tx_clk), .tx_reset(tx_reset), .pause_req(pause_req),
        .pause_time_req(pause_time_req), .mac_addr(mac_addr),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ack(in_ack),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ack(out_ack),
        .pause_busy(pause_busy), .pause_sent_cnt(pause_sent_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic push_pause(input logic [15:0] t);
        logic [47:0] m;
        m = 48'h001122334455;
        push_byte(8'h01, 0); push_byte(8'h80, 0); push_byte(8'hC2, 0);
        push_byte(8'h00, 0); push_byte(8'h00, 0); push_byte(8'h01, 0);
        for (int i = 5; i >= 0; i--) push_byte(m[i*8 +: 8], 0);
        push_byte(8'h88, 0); push_byte(8'h08, 0); push_byte(8'h00, 0); push_byte(8'h01, 0);
        push_byte(t[15:8], 0); push_byte(t[7:0], 0);
        for (int i = 18; i < 60; i++) push_byte(8'h00, i == 59);
    endtask

    task automatic push_user(input int n, input logic [7:0] seed);
        for (int i = 0; i < n; i++) push_byte(seed + 8'(i), i == n - 1);
    endtask

    task automatic pulse(input logic [15:0] t);
        pause_req = 1'b1;
        pause_time_req = t;
        @(posedge tx_clk); #1;
        pause_req = 1'b0;
    endtask

    task automatic send_user(input int n, input logic [7:0] seed);
        int t;
        user_sent = 0;
        for (int i = 0; i < n; i++) begin
            in_data = seed + 8'(i);
            in_valid = 1'b1;
            in_last = (i == n - 1);
            t = 0;
            do begin
                @(negedge tx_clk);
                t++;
            end while (!in_ack && t < 300);
            if (!in_ack) check("user_ack_timeout", 32'(in_ack), 32'd1);
            user_sent++;
            @(posedge tx_clk); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_sent(input int n);
        int t = 0;
        while (user_sent < n && t < 2000) begin
            @(posedge tx_clk);
            t++;
        end
        #1;
    endtask

    task automatic drain();
        int t = 0;
        @(negedge tx_clk);
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            @(negedge tx_clk);
            t++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge tx_clk); #1;
    endtask

    initial begin
        out_ack = 1'b1;
        forever begin
            @(posedge tx_clk); #1;
            out_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard pop, stall-stability and inter-frame gap checks.
    initial begin
        exp_t       e;
        logic       prev_stall, prev_end, prev_last;
        logic [7:0] prev_data;
        prev_stall = 0; prev_end = 0; prev_last = 0; prev_data = 0;
        forever begin
            @(negedge tx_clk);
            if (!mon_en) begin
                prev_stall = 0;
                prev_end = 0;
            end else begin
                if (prev_end) check("gap_valid", 32'(out_valid), 32'd0);
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'(out_data), 32'(prev_data));
                    check("stall_last", 32'(out_last), 32'(prev_last));
                end
                if (out_valid && out_ack) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.d));
                        check("out_last", 32'(out_last), 32'(e.l));
                    end
                end
                prev_stall = out_valid && !out_ack;
                prev_end = out_valid && out_ack && out_last;
                prev_data = out_data;
                prev_last = out_last;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        tx_reset = 1'b1;
        pause_req = 1'b1;
        pause_time_req = 16'hDEAD;
        mac_addr = 48'h001122334455;
        in_data = 8'h00;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (3) @(posedge tx_clk);
        @(negedge tx_clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ack", 32'(in_ack), 32'd0);
        check("rst_busy", 32'(pause_busy), 32'd0);
        check("rst_cnt", 32'(pause_sent_cnt), 32'd0);
        @(posedge tx_clk); #1;
        tx_reset = 1'b0;
        pause_req = 1'b0;
        repeat (2) @(posedge tx_clk); #1;

        // Basic PAUSE from idle, with one IDLE cycle before the frame.
        push_pause(16'h1234);
        pulse(16'h1234);
        @(negedge tx_clk);
        check("t1_idle_gap_valid", 32'(out_valid), 32'd0);
        check("t1_busy", 32'(pause_busy), 32'd1);
        @(negedge tx_clk);
        check("t1_start_valid", 32'(out_valid), 32'd1);
        drain();
        check("t1_cnt", 32'(pause_sent_cnt), 32'd1);
        check("t1_busy_end", 32'(pause_busy), 32'd0);

        // Request mid user frame waits for the frame boundary.
        push_user(100, 8'h20);
        push_pause(16'h00FF);
        fork
            send_user(100, 8'h20);
            begin wait_sent(10); pulse(16'h00FF); end
        join
        drain();
        check("t2_cnt", 32'(pause_sent_cnt), 32'd2);

        // Two requests during one user frame collapse to one frame, latest time.
        push_user(50, 8'h80);
        push_pause(16'h0200);
        fork
            send_user(50, 8'h80);
            begin
                wait_sent(5); pulse(16'h0100);
                wait_sent(20); pulse(16'h0200);
            end
        join
        drain();
        check("t3_cnt", 32'(pause_sent_cnt), 32'd3);

        // Random backpressure during a PAUSE frame.
        rand_ack = 1;
        push_pause(16'hABCD);
        pulse(16'hABCD);
        drain();
        rand_ack = 0;
        @(posedge tx_clk); #1;
        check("t4_cnt", 32'(pause_sent_cnt), 32'd4);

        // pend and in_valid together in IDLE: PAUSE wins, user waits.
        push_pause(16'h0042);
        push_user(10, 8'h40);
        pulse(16'h0042);
        fork
            send_user(10, 8'h40);
            begin
                for (int i = 0; i < 61; i++) begin
                    @(negedge tx_clk);
                    if (in_ack !== 1'b0) check("t5_in_ack_held", 32'(in_ack), 32'd0);
                end
                check("t5_in_ack_end", 32'(in_ack), 32'd0);
            end
        join
        drain();
        check("t5_cnt", 32'(pause_sent_cnt), 32'd5);

        // Reset mid-frame at idx 30, with a request held during reset.
        mon_en = 0;
        pulse(16'h7777);
        t = 0;
        do begin @(negedge tx_clk); t++; end while (!out_valid && t < 20);
        check("t6_started", 32'(out_valid), 32'd1);
        repeat (30) @(posedge tx_clk);
        #1;
        tx_reset = 1'b1;
        pause_req = 1'b1;
        pause_time_req = 16'h0005;
        @(posedge tx_clk); #1;
        tx_reset = 1'b0;
        pause_req = 1'b0;
        @(negedge tx_clk);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(pause_busy), 32'd0);
        check("t6_cnt", 32'(pause_sent_cnt), 32'd0);
        @(negedge tx_clk);
        check("t6_busy_late", 32'(pause_busy), 32'd0);
        @(posedge tx_clk); #1;
        mon_en = 1;
        push_pause(16'h0000);
        pulse(16'h0000);
        drain();
        check("t6_cnt_after", 32'(pause_sent_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_pause_inject.md
Name: tx_pause_inject

Overview:
- Transmit-domain stage directly downstream of the RX flow-control block. Consumes its pause_req pulse and pause_time_req value, and builds an IEEE 802.3x MAC-control PAUSE frame.
- Inserts that frame into the byte stream going to the TX MAC, only at user-frame boundaries.
- PAUSE frames take priority over pending user frames. FCS and preamble are added by the downstream MAC.

Parameters:
- CNT_WIDTH, 16, width of the sent-PAUSE-frame statistics counter.

Ports:
- tx_clk  in  1  transmit clock; all logic on its rising edge.
- tx_reset  in  1  synchronous, active-high reset.
- pause_req  in  1  single-cycle request pulse from the RX flow-control stage.
- pause_time_req  in  16  quanta value to send; valid when pause_req=1.
- mac_addr  in  48  station address used as the PAUSE source address; quasi-static.
- in_data  in  8  user frame byte.
- in_valid  in  1  user byte valid.
- in_last  in  1  marks the final byte of a user frame.
- in_ack  out  1  user byte accepted this cycle.
- out_data  out  8  byte to the MAC.
- out_valid  out  1  output byte valid.
- out_last  out  1  final byte of the output frame.
- out_ack  in  1  MAC accepts the output byte this cycle.
- pause_busy  out  1  high while a PAUSE frame is pending or being sent.
- pause_sent_cnt  out  CNT_WIDTH  number of completed PAUSE frames; wraps.

Behaviour:
- Handshake: a byte transfers on a cycle with valid=1 and ack=1. Once out_valid is asserted, out_data and out_last stay stable until out_ack.
- Request latch:
  - pause_req=1 sets pend and loads pend_time <= pause_time_req.
  - A further pulse while pend=1 overwrites pend_time; the latest value wins and only one frame is sent.
- State machine IDLE / USER / PAUSE. Reset state is IDLE.
- IDLE:
  - out_valid=0, in_ack=0.
  - If pend=1: go to PAUSE, load frame_time <= pend_time, clear pend, clear byte index idx to 0.
  - Else if in_valid=1: go to USER.
  - pend has priority when both are true in the same cycle.
- pause_req arriving in the same cycle that IDLE consumes pend: pend stays set with the new time, giving a second frame afterwards.
- USER:
  - Combinational pass-through: out_data=in_data, out_valid=in_valid, out_last=in_last, in_ack=out_ack.
  - On acceptance of a byte with in_last=1, go to IDLE.
  - pause_req arriving during USER only latches pend. A user frame is never cut.
- PAUSE:
  - in_ack=0, out_valid=1. idx is 6 bits, 0..59, and advances on each out_ack.
  - Byte map:
    - idx 0-5: 01 80 C2 00 00 01.
    - idx 6-11: mac_addr[47:40] first, down to [7:0].
    - idx 12-13: 88 08.
    - idx 14-15: 00 01.
    - idx 16: frame_time[15:8].
    - idx 17: frame_time[7:0].
    - idx 18-59: 00.
  - out_last=1 at idx 59.
  - On acceptance of idx 59: pause_sent_cnt increments (wrapping at 2^CNT_WIDTH), then go to IDLE.
- Inter-frame: at least one IDLE cycle, with out_valid=0, between any two output frames.
- pause_time_req=0 is legal and is sent as-is (XON frame).
- pause_busy = pend | (state==PAUSE).
- Reset (any state, including mid-frame):
  - state=IDLE, pend=0, pend_time=0, frame_time=0, idx=0, pause_sent_cnt=0.
  - out_valid=0, out_last=0, out_data=0, in_ack=0, pause_busy=0.
  - The partially sent frame is abandoned; the MAC sees valid drop.
  - pause_req asserted during reset is ignored.

Test Plan:
- Idle, mac_addr=0x001122334455, pause_req pulse with pause_time_req=0x1234 -> after one IDLE cycle, 60 bytes with out_ack held high: 01 80 C2 00 00 01 00 11 22 33 44 55 88 08 00 01 12 34, then 42×00, out_last on byte 60, pause_sent_cnt=1.
- User frame of 100 bytes in progress; pause_req (time 0x00FF) at byte 10 -> all 100 user bytes pass unbroken, then ≥1 idle cycle, then a PAUSE frame carrying 00 FF.
- Two pause_req pulses (0x0100, then 0x0200) while a user frame is active -> exactly one PAUSE frame follows, carrying 02 00.
- out_ack toggled randomly (50%) during a PAUSE frame -> byte order and values unchanged, out_data stable while out_ack=0, still 60 bytes.
- in_valid and pend both true in IDLE -> PAUSE frame goes first; the user frame starts after the intervening IDLE cycle, with in_ack=0 until then.
- tx_reset asserted at PAUSE idx 30 -> the next cycle has out_valid=0, pause_busy=0 and pause_sent_cnt=0; a fresh pause_req afterwards produces a full frame starting at idx 0.
